// File: rtl/image_copy_master.sv
// Block-copy bus initiator: moves len words from src_base to dst_base (RAM only).
// Ports: i_clk/i_rst (sync, active-high); i_start, i_abort, i_src_base, i_dst_base,
//        i_len: request side; o_busy, o_done, o_err, o_count: status;
//        o_addr, o_we, o_wd, i_rd: single-port memory bus (RD_LAT = 0 or 1).
module image_copy_master #(
   parameter int unsigned RD_LAT = 1,
   parameter logic [31:0] RAM_LO = 32'd152100,
   parameter logic [31:0] RAM_HI = 32'd304455,
   parameter logic [31:0] MEM_HI = 32'd304455
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [31:0] i_src_base,
   input  logic [31:0] i_dst_base,
   input  logic [31:0] i_len,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] o_count,
   output logic [31:0] o_addr,
   output logic        o_we,
   output logic [31:0] o_wd,
   input  logic [31:0] i_rd
);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_READ, S_WAIT, S_WRITE, S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_src;
   logic [31:0] r_dst;
   logic [31:0] r_len;
   logic [31:0] r_data;
   logic [31:0] r_count;
   logic        r_err;

   // End addresses in 33 bits so a huge base+len cannot wrap past the limits.
   logic [32:0] w_src_end;
   logic [32:0] w_dst_end;
   logic        w_bad;
   logic        w_last;

   assign w_src_end = {1'b0, r_src} + {1'b0, r_len} - 33'd1;
   assign w_dst_end = {1'b0, r_dst} + {1'b0, r_len} - 33'd1;
   assign w_bad     = (r_dst < RAM_LO)
                   || (w_dst_end > {1'b0, RAM_HI})
                   || (w_src_end > {1'b0, MEM_HI});
   // The word index and the written-word count are the same quantity.
   assign w_last    = ((r_count + 32'd1) == r_len);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (i_start) w_next = S_CHECK;
         S_CHECK: begin
            if (r_len == 32'd0) w_next = S_DONE;
            else if (w_bad)     w_next = S_DONE;
            else                w_next = S_READ;
         end
         S_READ: begin
            if (i_abort)          w_next = S_DONE;
            else if (RD_LAT == 0) w_next = S_WRITE;
            else                  w_next = S_WAIT;
         end
         S_WAIT:  w_next = i_abort ? S_DONE : S_WRITE;
         S_WRITE: w_next = (i_abort || w_last) ? S_DONE : S_READ;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Bus and status are decoded from registered state only.
   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      o_addr = 32'd0;
      o_we   = 1'b0;
      o_wd   = 32'd0;
      unique case (r_state)
         S_IDLE:  ;
         S_CHECK: o_busy = 1'b1;
         S_READ, S_WAIT: begin
            o_busy = 1'b1;
            o_addr = r_src + r_count;
         end
         S_WRITE: begin
            o_busy = 1'b1;
            o_addr = r_dst + r_count;
            o_we   = 1'b1;
            o_wd   = r_data;
         end
         S_DONE:  o_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_src   <= 32'd0;
         r_dst   <= 32'd0;
         r_len   <= 32'd0;
         r_data  <= 32'd0;
         r_count <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_src   <= i_src_base;
                  r_dst   <= i_dst_base;
                  r_len   <= i_len;
                  r_count <= 32'd0;
                  r_err   <= 1'b0;
               end
            end
            S_CHECK: begin
               if ((r_len != 32'd0) && w_bad) r_err <= 1'b1;
            end
            S_READ: begin
               if (i_abort)          r_err  <= 1'b1;
               else if (RD_LAT == 0) r_data <= i_rd;
            end
            S_WAIT: begin
               if (i_abort) r_err  <= 1'b1;
               else         r_data <= i_rd;
            end
            S_WRITE: begin
               if (r_count != r_len) r_count <= r_count + 32'd1;
               if (i_abort)          r_err   <= 1'b1;
            end
            S_DONE:  ;
            default: ;
         endcase
      end
   end

   assign o_err   = r_err;
   assign o_count = r_count;

endmodule

// File: tb/tb_image_copy_master.sv
// Bench for image_copy_master: RD_LAT=1 and RD_LAT=0 instances against a
// word-level copy model, directed vector table plus randomized transfers.
module tb_image_copy_master;

   localparam logic [31:0] RAM_LO = 32'd152100;
   localparam logic [31:0] RAM_HI = 32'd304455;
   localparam logic [31:0] MEM_HI = 32'd304455;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start_v;
   logic        abort;
   logic [31:0] src, dst, len;

   logic        busy1, done1, err1, we1;
   logic [31:0] cnt1, addr1, wd1, rd1;
   logic        busy0, done0, err0, we0;
   logic [31:0] cnt0, addr0, wd0, rd0;

   int          sel;
   logic        ob_busy, ob_done, ob_err, ob_we;
   logic [31:0] ob_cnt, ob_addr, ob_wd;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   image_copy_master #(.RD_LAT(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .i_abort(abort),
      .i_src_base(src), .i_dst_base(dst), .i_len(len),
      .o_busy(busy1), .o_done(done1), .o_err(err1), .o_count(cnt1),
      .o_addr(addr1), .o_we(we1), .o_wd(wd1), .i_rd(rd1)
   );

   image_copy_master #(.RD_LAT(0)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .i_abort(abort),
      .i_src_base(src), .i_dst_base(dst), .i_len(len),
      .o_busy(busy0), .o_done(done0), .o_err(err0), .o_count(cnt0),
      .o_addr(addr0), .o_we(we0), .o_wd(wd0), .i_rd(rd0)
   );

   always_comb begin
      ob_busy = (sel != 0) ? busy1 : busy0;
      ob_done = (sel != 0) ? done1 : done0;
      ob_err  = (sel != 0) ? err1  : err0;
      ob_we   = (sel != 0) ? we1   : we0;
      ob_cnt  = (sel != 0) ? cnt1  : cnt0;
      ob_addr = (sel != 0) ? addr1 : addr0;
      ob_wd   = (sel != 0) ? wd1   : wd0;
   end

   // Memory: unwritten words follow a fixed pattern, written words overlay it.
   logic [31:0] mem1 [int unsigned];
   logic [31:0] mem0 [int unsigned];
   logic [63:0] log1 [$];
   logic [63:0] log0 [$];
   int          ver0 = 0;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return a * 32'h9E3779B1 + 32'h01234567;
   endfunction

   function automatic logic [31:0] rdm1(input logic [31:0] a);
      if (mem1.exists(a)) return mem1[a];
      return rom(a);
   endfunction

   function automatic logic [31:0] rdm0(input logic [31:0] a);
      if (mem0.exists(a)) return mem0[a];
      return rom(a);
   endfunction

   initial rd1 = 32'd0;
   always @(posedge clk) rd1 <= rdm1(addr1);
   always @(addr0, ver0) rd0 = rdm0(addr0);

   always @(posedge clk) begin
      if (we1) begin
         mem1[addr1] = wd1;
         log1.push_back({addr1, wd1});
      end
      if (we0) begin
         mem0[addr0] = wd0;
         log0.push_back({addr0, wd0});
         ver0++;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected write list: an ascending word-by-word copy over a private
   // snapshot of memory, so overlapping ranges replicate naturally.
   task automatic model_writes(input int s, input logic [31:0] sa,
                               input logic [31:0] da, input int nw,
                               output logic [63:0] q [$]);
      logic [31:0] t [int unsigned];
      logic [31:0] a, v;
      q = {};
      if (s != 0) t = mem1;
      else        t = mem0;
      for (int i = 0; i < nw; i++) begin
         a = sa + i;
         v = t.exists(a) ? t[a] : rom(a);
         t[da + i] = v;
         q.push_back({da + 32'(i), v});
      end
   endtask

   // Status outcome from the rules: range check, per-word cost 2+RD_LAT,
   // abort at cycle ac (cycle 1 = first cycle after the start edge).
   task automatic model_status(input int lat, input logic [31:0] sa,
                               input logic [31:0] da, input logic [31:0] n,
                               input int ac, output int e_err,
                               output int e_nw, output int e_done);
      int per;
      logic [32:0] se, de;
      per = 2 + lat;
      se  = {1'b0, sa} + {1'b0, n} - 33'd1;
      de  = {1'b0, da} + {1'b0, n} - 33'd1;
      if (n == 0) begin
         e_err = 0; e_nw = 0; e_done = 2;
      end else if (da < RAM_LO || de > {1'b0, RAM_HI}
                   || se > {1'b0, MEM_HI}) begin
         e_err = 1; e_nw = 0; e_done = 2;
      end else if (ac >= 2 && ac <= 1 + int'(n) * per) begin
         e_err  = 1;
         e_nw   = ((ac - 2) % per == per - 1) ? (ac - 2) / per + 1
                                             : (ac - 2) / per;
         e_done = ac + 1;
      end else begin
         e_err = 0; e_nw = int'(n); e_done = 2 + int'(n) * per;
      end
   endtask

   task automatic run(input int s, input logic [31:0] sa,
                      input logic [31:0] da, input logic [31:0] n,
                      input int ac, input int spur, input int e_err,
                      input int e_nw, input int e_done, input string nm);
      logic [63:0] q [$];
      logic [63:0] got [$];
      int donec, gaps, derr, dcnt, nchk;
      model_writes(s, sa, da, e_nw, q);
      sel = s;
      if (s != 0) log1.delete();
      else        log0.delete();
      @(negedge clk);
      src = sa; dst = da; len = n;
      start_v[s] = 1'b1;
      @(posedge clk);
      #1 start_v = 2'b00;
      donec = 0; gaps = 0; derr = 0; dcnt = 0;
      for (int c = 1; c <= e_done + 20 && donec == 0; c++) begin
         @(negedge clk);
         abort = (c == ac);
         if (c == spur) begin
            src = ~sa; dst = RAM_LO + 32'd100; len = 32'd7;
            start_v[s] = 1'b1;
         end else begin
            start_v = 2'b00;
         end
         if (ob_done) begin
            donec = c;
            derr  = int'(ob_err);
            dcnt  = int'(ob_cnt);
            if (ob_busy) gaps++;
         end else if (!ob_busy) begin
            gaps++;
         end
      end
      abort = 1'b0;
      if (spur < 0) start_v[s] = 1'b1;
      @(posedge clk);
      #1 start_v = 2'b00;
      chk({nm, " done_cycle"}, 64'(donec), 64'(e_done));
      chk({nm, " busy_profile"}, 64'(gaps), 64'd0);
      chk({nm, " err"}, 64'(derr), 64'(e_err));
      chk({nm, " count"}, 64'(dcnt), 64'(e_nw));
      @(negedge clk);
      chk({nm, " done_one_cycle"}, {62'd0, ob_done, ob_busy}, 64'd0);
      chk({nm, " err_held"}, 64'(ob_err), 64'(e_err));
      if (s != 0) got = log1;
      else        got = log0;
      chk({nm, " n_writes"}, 64'(got.size()), 64'(q.size()));
      nchk = (got.size() < q.size()) ? got.size() : q.size();
      for (int i = 0; i < nchk; i++)
         chk($sformatf("%s write%0d", nm, i), got[i], q[i]);
   endtask

   typedef struct {
      int          s;
      logic [31:0] sa, da, n;
      int          ac, spur, e_err, e_nw, e_done;
      string       nm;
   } vec_t;

   vec_t tbl [$];

   initial begin
      int e_err, e_nw, e_done, lat, mode, ac, spur, s;
      logic [31:0] sa, da, n;

      tbl.push_back('{1, 0, RAM_LO, 4, 0, 0, 0, 4, 14, "basic"});
      tbl.push_back('{1, 0, RAM_LO, 0, 0, 0, 0, 0, 2, "zero_len"});
      tbl.push_back('{1, 0, RAM_LO - 1, 1, 0, 0, 1, 0, 2, "dst_below"});
      tbl.push_back('{1, 0, RAM_HI, 2, 0, 0, 1, 0, 2, "dst_past_end"});
      tbl.push_back('{1, 0, RAM_HI, 1, 0, 0, 0, 1, 5, "dst_last"});
      tbl.push_back('{1, MEM_HI, RAM_LO, 2, 0, 0, 1, 0, 2, "src_past_end"});
      tbl.push_back('{1, 0, 32'hFFFFFFFF, 2, 0, 0, 1, 0, 2, "dst_wrap"});
      tbl.push_back('{1, 10, RAM_LO + 20, 5, 9, 0, 1, 2, 10, "abort_wait"});
      tbl.push_back('{1, 20, RAM_LO + 30, 3, 7, 0, 1, 2, 8, "abort_write"});
      tbl.push_back('{1, 50, RAM_LO + 40, 4, 0, 5, 0, 4, 14, "start_busy"});
      tbl.push_back('{1, 60, RAM_LO + 60, 2, 0, -1, 0, 2, 8, "start_done"});
      tbl.push_back('{0, 0, RAM_LO + 200, 3, 0, 0, 0, 3, 8, "lat0_len3"});
      tbl.push_back('{0, RAM_LO + 1000, RAM_LO + 1001, 4, 0, 0, 0, 4, 10,
                       "lat0_overlap"});
      tbl.push_back('{0, 5, RAM_LO + 300, 4, 6, 0, 1, 2, 7, "lat0_abort_rd"});

      mem1[0] = 32'hAAAA0001;
      mem1[1] = 32'hBBBB0002;
      mem1[2] = 32'hCCCC0003;
      mem1[3] = 32'hDDDD0004;

      sel = 1;
      rst = 1'b1; start_v = 2'b00; abort = 1'b0;
      src = 32'd0; dst = 32'd0; len = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst busy", {63'd0, busy1}, 64'd0);
      chk("rst done", {63'd0, done1}, 64'd0);
      chk("rst err", {63'd0, err1}, 64'd0);
      chk("rst count", {32'd0, cnt1}, 64'd0);
      chk("rst addr", {32'd0, addr1}, 64'd0);
      chk("rst we_wd", {31'd0, we1, wd1}, 64'd0);
      chk("rst lat0", {29'd0, busy0, done0, err0, we0, cnt0}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      foreach (tbl[k])
         run(tbl[k].s, tbl[k].sa, tbl[k].da, tbl[k].n, tbl[k].ac,
             tbl[k].spur, tbl[k].e_err, tbl[k].e_nw, tbl[k].e_done,
             tbl[k].nm);

      // First basic word must be the preloaded A.
      chk("basic first data", {32'd0, mem1[RAM_LO]}, 64'hAAAA0001);

      // Reset asserted in the WRITE cycle of word 1.
      sel = 1;
      log1.delete();
      @(negedge clk);
      src = 32'd100; dst = RAM_LO + 32'd500; len = 32'd5;
      start_v[1] = 1'b1;
      @(posedge clk);
      #1 start_v = 2'b00;
      for (int c = 1; c <= 7; c++) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid we", {63'd0, we1}, 64'd0);
      chk("rst_mid busy", {63'd0, busy1}, 64'd0);
      chk("rst_mid count", {32'd0, cnt1}, 64'd0);
      chk("rst_mid addr", {32'd0, addr1}, 64'd0);
      begin
         int seen;
         seen = 0;
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done1 || we1) seen++;
         end
         chk("rst_mid no_done", 64'(seen), 64'd0);
      end
      chk("rst_mid writes", 64'(log1.size()), 64'd2);

      // Randomized transfers against the model.
      for (int r = 0; r < 24; r++) begin
         s    = r % 2;
         lat  = s;
         mode = int'($urandom_range(0, 3));
         n    = 32'($urandom_range(0, 6));
         case (mode)
            0: begin
               sa = 32'($urandom_range(0, 152000));
               da = RAM_LO + 32'($urandom_range(0, 100000));
            end
            1: begin
               sa = RAM_LO + 32'($urandom_range(2000, 3000));
               da = sa + 32'($urandom_range(1, 3));
            end
            2: begin
               sa = 32'($urandom_range(0, 1000));
               da = RAM_HI - 32'($urandom_range(0, 6));
            end
            default: begin
               sa = MEM_HI - 32'($urandom_range(0, 6));
               da = RAM_LO + 32'($urandom_range(0, 50));
            end
         endcase
         ac = 0;
         if ($urandom_range(0, 2) == 0)
            ac = int'($urandom_range(2, 2 + int'(n) * (2 + lat)));
         model_status(lat, sa, da, n, ac, e_err, e_nw, e_done);
         spur = 0;
         if ($urandom_range(0, 3) == 0)
            spur = int'($urandom_range(1, e_done));
         run(s, sa, da, n, ac, spur, e_err, e_nw, e_done,
             $sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
